// File: rtl/eeprom_arb_if.sv
// eeprom_arb_if: request/response bundle for both requesters plus the eeprom pin group.
// The slave side is the arbiter; the master side is the requesters and the eeprom device.
interface eeprom_arb_if #(
   parameter int AW = 4,
   parameter int DW = 32
);
   logic          r0_req, r0_we, r0_gnt, r0_done, r0_verr;
   logic [AW-1:0] r0_a;
   logic [DW-1:0] r0_wd, r0_rd;
   logic          r1_req, r1_we, r1_gnt, r1_done, r1_verr;
   logic [AW-1:0] r1_a;
   logic [DW-1:0] r1_wd, r1_rd;
   logic          ee_str, ee_ld;
   logic [AW-1:0] ee_a;
   logic [DW-1:0] ee_din, ee_d;
   logic          busy;

   modport slave (
      input  r0_req, r0_we, r0_a, r0_wd, r1_req, r1_we, r1_a, r1_wd, ee_d,
      output r0_gnt, r0_done, r0_rd, r0_verr, r1_gnt, r1_done, r1_rd, r1_verr,
             ee_str, ee_ld, ee_a, ee_din, busy
   );

   modport master (
      output r0_req, r0_we, r0_a, r0_wd, r1_req, r1_we, r1_a, r1_wd, ee_d,
      input  r0_gnt, r0_done, r0_rd, r0_verr, r1_gnt, r1_done, r1_rd, r1_verr,
             ee_str, ee_ld, ee_a, ee_din, busy
   );
endinterface

// File: rtl/eeprom_arb.sv
// eeprom_arb: round-robin arbiter and pin sequencer for the 16x32 eeprom shared by R0 (host) and R1 (display).
// Define EEPROM_WR_VERIFY_EN to add a read-back verify pass after every write.
module eeprom_arb #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   eeprom_arb_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, WR, WREC, RD, RCAP
`ifdef EEPROM_WR_VERIFY_EN
      , VLD, VCAP
`endif
   } state_t;

   state_t        state_q;
   logic          last_q;   // 1: R1 was served last, so R0 wins the next tie
   logic          owner_q;
   logic          busy_q, str_q, ld_q;
   logic          gnt0_q, gnt1_q, done0_q, done1_q;
   logic [AW-1:0] a_q;
   logic [DW-1:0] din_q, rd0_q, rd1_q;
   logic          acc_d, win_d, we_d;
   logic [AW-1:0] a_d;
   logic [DW-1:0] din_d;
`ifdef EEPROM_WR_VERIFY_EN
   logic          verr0_q, verr1_q;
`endif

   always_comb begin
      acc_d = bus.r0_req | bus.r1_req;
      win_d = ~bus.r0_req | (bus.r1_req & ~last_q);
      we_d  = win_d ? bus.r1_we : bus.r0_we;
      a_d   = win_d ? bus.r1_a  : bus.r0_a;
      din_d = win_d ? bus.r1_wd : bus.r0_wd;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         busy_q  <= 1'b0;
         str_q   <= 1'b0;
         ld_q    <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         a_q     <= '0;
         din_q   <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
`ifdef EEPROM_WR_VERIFY_EN
         verr0_q <= 1'b0;
         verr1_q <= 1'b0;
`endif
      end else begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
`ifdef EEPROM_WR_VERIFY_EN
         verr0_q <= 1'b0;
         verr1_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (acc_d) begin
                  owner_q <= win_d;
                  last_q  <= win_d;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
                  a_q     <= a_d;
                  din_q   <= din_d;
                  busy_q  <= 1'b1;
                  if (we_d) begin
                     state_q <= WR;
                     str_q   <= 1'b1;
                  end else begin
                     state_q <= RD;
                     ld_q    <= 1'b1;
                  end
               end
            end
            WR: begin
               str_q   <= 1'b0;
               state_q <= WREC;
            end
            WREC: begin
`ifdef EEPROM_WR_VERIFY_EN
               state_q <= VLD;
               ld_q    <= 1'b1;
`else
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done0_q <= ~owner_q;
               done1_q <= owner_q;
`endif
            end
            RD: state_q <= RCAP;
            RCAP: begin
               // ee_d reflects the address sampled at the end of RD
               if (owner_q) rd1_q <= bus.ee_d;
               else         rd0_q <= bus.ee_d;
               ld_q    <= 1'b0;
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done0_q <= ~owner_q;
               done1_q <= owner_q;
            end
`ifdef EEPROM_WR_VERIFY_EN
            VLD: state_q <= VCAP;
            VCAP: begin
               verr0_q <= ~owner_q & (bus.ee_d != din_q);
               verr1_q <= owner_q & (bus.ee_d != din_q);
               ld_q    <= 1'b0;
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done0_q <= ~owner_q;
               done1_q <= owner_q;
            end
`endif
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               str_q   <= 1'b0;
               ld_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.r0_gnt  = gnt0_q;
   assign bus.r1_gnt  = gnt1_q;
   assign bus.r0_done = done0_q;
   assign bus.r1_done = done1_q;
   assign bus.r0_rd   = rd0_q;
   assign bus.r1_rd   = rd1_q;
   assign bus.ee_str  = str_q;
   assign bus.ee_ld   = ld_q;
   assign bus.ee_a    = a_q;
   assign bus.ee_din  = din_q;
   assign bus.busy    = busy_q;
`ifdef EEPROM_WR_VERIFY_EN
   assign bus.r0_verr = verr0_q;
   assign bus.r1_verr = verr1_q;
`else
   assign bus.r0_verr = 1'b0;
   assign bus.r1_verr = 1'b0;
`endif
endmodule

// File: tb/tb_eeprom_arb.sv
// tb_eeprom_arb: randomized scoreboard bench for eeprom_arb with a behavioural eeprom device.
// Expected per-port responses are queued at issue time and checked by an independent monitor.
module tb_eeprom_arb;
`ifdef EEPROM_WR_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   typedef struct {
      bit          we;
      logic [3:0]  a;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          verr;
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   eeprom_arb_if #(.AW(4), .DW(32)) bus ();
   eeprom_arb #(.AW(4), .DW(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   op_t         q0[$];
   op_t         q1[$];
   logic [31:0] ref_mem [16];
   logic [31:0] dev_mem [16];
   bit          dev_init = 1'b0;
   bit          corrupt = 1'b0;
   bit          chk_alt = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // eeprom device: commits on a sampled store strobe, returns data one cycle after a sampled load
   always @(posedge clk) begin
      if (!dev_init) begin
         for (int i = 0; i < 16; i++) dev_mem[i] <= 32'hA5A5_0000 + i;
         dev_init <= 1'b1;
      end else if (bus.ee_str) begin
         dev_mem[bus.ee_a] <= corrupt ? (bus.ee_din ^ 32'h1) : bus.ee_din;
      end
      if (bus.ee_ld) bus.ee_d <= dev_mem[bus.ee_a];
   end

   // monitor / scoreboard
   op_t         inf;
   bit          inf_vld = 1'b0;
   int          inf_p, gnt_cyc, str_n, ld_n, prev_p, prev_cyc;
   bit          prev_vld = 1'b0;
   bit          prev_str = 1'b0;
   logic [31:0] exp_rd0 = '0;
   logic [31:0] exp_rd1 = '0;

   always @(negedge clk) begin : mon
      int p;
      if (rst) begin
         inf_vld  = 1'b0;
         exp_rd0  = '0;
         exp_rd1  = '0;
         prev_vld = 1'b0;
         prev_str = 1'b0;
      end else begin
         if (!chk_alt) prev_vld = 1'b0;
         if (bus.ee_str | bus.ee_ld) chk("str_ld_excl", 64'(bus.ee_str & bus.ee_ld), 64'(0));
         if (bus.ee_str) chk("str_width", 64'(prev_str), 64'(0));
         if (bus.r0_gnt | bus.r1_gnt) begin
            p = bus.r1_gnt ? 1 : 0;
            chk("gnt_onehot", 64'(bus.r0_gnt & bus.r1_gnt), 64'(0));
            chk("gnt_while_busy", 64'(inf_vld), 64'(0));
            chk("busy_at_gnt", 64'(bus.busy), 64'(1));
            if (chk_alt && prev_vld) begin
               chk("alt_port", 64'(p), 64'(1 - prev_p));
               chk("gnt_spacing", 64'(cyc - prev_cyc), 64'(3));
            end
            prev_vld = 1'b1;
            prev_p   = p;
            prev_cyc = cyc;
            chk("gnt_has_req", 64'((p == 1) ? (q1.size() != 0) : (q0.size() != 0)), 64'(1));
            if (p == 1 && q1.size() != 0) begin
               inf = q1.pop_front();
               inf_vld = 1'b1;
            end else if (p == 0 && q0.size() != 0) begin
               inf = q0.pop_front();
               inf_vld = 1'b1;
            end
            inf_p   = p;
            gnt_cyc = cyc;
            str_n   = 0;
            ld_n    = 0;
         end
         if (inf_vld) begin
            str_n += int'(bus.ee_str);
            ld_n  += int'(bus.ee_ld);
            if (bus.ee_str | bus.ee_ld) chk("ee_a", 64'(bus.ee_a), 64'(inf.a));
            if (bus.ee_str) chk("ee_din", 64'(bus.ee_din), 64'(inf.wd));
         end
         if (bus.r0_done | bus.r1_done) begin
            chk("done_onehot", 64'(bus.r0_done & bus.r1_done), 64'(0));
            chk("done_has_op", 64'(inf_vld), 64'(1));
            if (inf_vld) begin
               chk("done_port", 64'(bus.r1_done), 64'(inf_p));
               chk("latency", 64'(cyc - gnt_cyc), 64'((inf.we && VER) ? 4 : 2));
               chk("str_cycles", 64'(str_n), 64'(inf.we ? 1 : 0));
               chk("ld_cycles", 64'(ld_n), 64'((!inf.we || VER) ? 2 : 0));
               chk("busy_at_done", 64'(bus.busy), 64'(0));
               if (!inf.we) begin
                  if (inf_p == 1) exp_rd1 = inf.rd;
                  else            exp_rd0 = inf.rd;
               end
               chk("verr", 64'((inf_p == 1) ? bus.r1_verr : bus.r0_verr), 64'(inf.verr));
               inf_vld = 1'b0;
            end
            chk("rd0", 64'(bus.r0_rd), 64'(exp_rd0));
            chk("rd1", 64'(bus.r1_rd), 64'(exp_rd1));
         end
         prev_str = bus.ee_str;
      end
   end

   // reference model: a plain memory image updated in issue order
   task automatic push_op(int p, bit we, logic [3:0] a, logic [31:0] wd);
      op_t o;
      o.we   = we;
      o.a    = a;
      o.wd   = wd;
      o.rd   = ref_mem[a];
      o.verr = 1'b0;
      if (we) begin
         ref_mem[a] = corrupt ? (wd ^ 32'h1) : wd;
         o.verr     = corrupt && VER;
      end
      if (p == 1) q1.push_back(o);
      else        q0.push_back(o);
   endtask

   task automatic set_port(int p, bit req, bit we, logic [3:0] a, logic [31:0] wd);
      if (p == 0) begin
         bus.r0_req = req; bus.r0_we = we; bus.r0_a = a; bus.r0_wd = wd;
      end else begin
         bus.r1_req = req; bus.r1_we = we; bus.r1_a = a; bus.r1_wd = wd;
      end
   endtask

   task automatic drop_req(int p);
      if (p == 0) bus.r0_req = 1'b0;
      else        bus.r1_req = 1'b0;
   endtask

   task automatic wait_pulse(int p, bit is_done, string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (is_done) seen = (p == 1) ? bus.r1_done : bus.r0_done;
         else         seen = (p == 1) ? bus.r1_gnt  : bus.r0_gnt;
      end
      chk(nm, 64'(seen), 64'(1));
   endtask

   task automatic do_op(int p, bit we, logic [3:0] a, logic [31:0] wd);
      push_op(p, we, a, wd);
      set_port(p, 1'b1, we, a, wd);
      wait_pulse(p, 1'b0, "gnt_seen");
      drop_req(p);
      wait_pulse(p, 1'b1, "done_seen");
   endtask

   task automatic stream(int p, int n);
      for (int k = 0; k < n; k++) begin
         logic [3:0]  a;
         logic [31:0] wd;
         a  = (p == 0) ? 4'(8 + k) : 4'(k);
         wd = $urandom();
         push_op(p, (p == 0), a, wd);
         set_port(p, 1'b1, (p == 0), a, wd);
         wait_pulse(p, 1'b0, "gnt_seen");
      end
      drop_req(p);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] save;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A5_0000 + i;
      set_port(0, 1'b0, 1'b0, 4'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 4'd0, 32'd0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_gnt", 64'({bus.r0_gnt, bus.r1_gnt}), 64'(0));
      chk("rst_done", 64'({bus.r0_done, bus.r1_done}), 64'(0));
      chk("rst_str_ld", 64'({bus.ee_str, bus.ee_ld}), 64'(0));
      chk("rst_ee_a_din", {28'd0, bus.ee_a, bus.ee_din}, 64'(0));
      chk("rst_rd", {bus.r0_rd, bus.r1_rd}, 64'(0));

      // single write then cross-port readback
      do_op(0, 1'b1, 4'd3, 32'hDEADBEEF);
      do_op(1, 1'b0, 4'd3, 32'd0);

      // sweep
      for (int i = 0; i < 16; i++) do_op(0, 1'b1, 4'(i), 32'(i + 1));
      for (int i = 0; i < 16; i++) do_op(1, 1'b0, 4'(i), 32'd0);

      // contention: both ports hold req continuously
      chk_alt = 1'b1;
      fork
         stream(0, 6);
         stream(1, 6);
      join
      repeat (4) @(posedge clk);
      #1 chk_alt = 1'b0;

      // abort a write of a=5 mid-WR; the device never commits it
      save = ref_mem[5];
      push_op(0, 1'b1, 4'd5, 32'h55);
      ref_mem[5] = save;
      set_port(0, 1'b1, 1'b1, 4'd5, 32'h55);
      wait_pulse(0, 1'b0, "gnt_seen");
      #5 rst = 1'b1;
      #1;
      chk("abort_str", 64'(bus.ee_str), 64'(0));
      chk("abort_ld", 64'(bus.ee_ld), 64'(0));
      chk("abort_gnt", 64'({bus.r0_gnt, bus.r1_gnt}), 64'(0));
      chk("abort_busy", 64'(bus.busy), 64'(0));
      chk("abort_ee_a_din", {28'd0, bus.ee_a, bus.ee_din}, 64'(0));
      chk("abort_rd", {bus.r0_rd, bus.r1_rd}, 64'(0));
      drop_req(0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_idle_busy", 64'(bus.busy), 64'(0));
      do_op(1, 1'b0, 4'd5, 32'd0);

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom());
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

`ifdef EEPROM_WR_VERIFY_EN
      corrupt = 1'b1;
      do_op(0, 1'b1, 4'd7, 32'h10);
      corrupt = 1'b0;
      do_op(1, 1'b0, 4'd7, 32'd0);
`endif

      repeat (4) @(posedge clk);
      #1;
      chk("drain", 64'(q0.size() + q1.size() + int'(inf_vld)), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
